avst_word_tx: RTL and testbench

Avalon-ST byte transmitter that takes packed multi-byte words from an upstream word interface and serializes them onto an 8-bit Avalon-ST source (data/valid/end/ready), honoring downstream backpressure. It sits in front of byte-wide AVST sinks such as the adder datapath and is the transmit end of the same streaming protocol. A one-word prefetch buffer sustains one byte per clock across word boundaries.

---
 rtl/avst_word_tx.sv | 147 ++++++++++++++
 tb/tb_avst_word_tx.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avst_word_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : avst_word_tx
//  Purpose  : Serializes packed multi-byte words onto an 8-bit Avalon-ST
//             source (data/valid/end/ready). A one-word prefetch register
//             keeps one byte per clock flowing across word boundaries.
//  Revision : 1.0  initial release
// ============================================================================
module avst_word_tx #(
   parameter int WORD_BYTES = 4,
   parameter int NB_W       = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [8*WORD_BYTES-1:0] word_in,
   input  logic [NB_W-1:0]         nbytes_in,
   input  logic                    last_in,
   input  logic                    word_valid,
   output logic                    word_ready,
   output logic [7:0]              data_out,
   output logic                    valid_out,
   output logic                    end_out,
   input  logic                    ready_out,
   output logic                    busy,
   output logic [15:0]             pkt_count
);

   localparam logic [NB_W-1:0] c_WORD_BYTES = NB_W'(WORD_BYTES);
   localparam logic [NB_W-1:0] c_ONE        = NB_W'(1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;

   // Shifter: byte 0 of the remaining data always sits in the low byte.
   logic [8*WORD_BYTES-1:0] r_sh_word;
   logic [NB_W-1:0]         r_sh_rem;
   logic                    r_sh_last;

   // Prefetch register.
   logic [8*WORD_BYTES-1:0] r_nxt_word;
   logic [NB_W-1:0]         r_nxt_nb;
   logic                    r_nxt_last;
   logic                    r_nxt_full;

   logic [15:0]             r_pkt_count;

   logic [NB_W-1:0]         w_nb_clamped;
   logic                    w_word_xfer;
   logic                    w_byte_xfer;
   logic                    w_final_xfer;
   logic                    w_load_direct;
   logic                    w_load_pref;
   logic                    w_to_prefetch;

   // word_ready looks only at the registered prefetch flag and reset, so
   // there is never a combinational path from ready_out.
   assign word_ready   = !r_nxt_full && !reset;
   assign w_word_xfer  = word_valid && word_ready;
   assign w_byte_xfer  = (r_state == ST_SEND) && ready_out;
   assign w_final_xfer = w_byte_xfer && (r_sh_rem == c_ONE);
   assign w_nb_clamped = ((nbytes_in == '0) || (nbytes_in > c_WORD_BYTES))
                         ? c_WORD_BYTES : nbytes_in;
   assign busy         = (r_state == ST_SEND) || r_nxt_full;
   assign pkt_count    = r_pkt_count;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state, stream outputs and load steering.
   always_comb begin
      w_state_nxt   = r_state;
      valid_out     = 1'b0;
      end_out       = 1'b0;
      data_out      = 8'h00;
      w_load_direct = 1'b0;
      w_load_pref   = 1'b0;
      w_to_prefetch = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_word_xfer) begin
               w_load_direct = 1'b1;
               w_state_nxt   = ST_SEND;
            end
         end
         ST_SEND: begin
            valid_out = 1'b1;
            data_out  = r_sh_word[7:0];
            end_out   = r_sh_last && (r_sh_rem == c_ONE);
            if (w_final_xfer) begin
               // Prefetch has priority; a new word cannot arrive while it is full.
               if (r_nxt_full)       w_load_pref   = 1'b1;
               else if (w_word_xfer) w_load_direct = 1'b1;
               else                  w_state_nxt   = ST_IDLE;
            end else if (w_word_xfer) begin
               w_to_prefetch = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Shifter, prefetch and packet counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sh_word   <= '0;
         r_sh_rem    <= '0;
         r_sh_last   <= 1'b0;
         r_nxt_word  <= '0;
         r_nxt_nb    <= '0;
         r_nxt_last  <= 1'b0;
         r_nxt_full  <= 1'b0;
         r_pkt_count <= 16'h0000;
      end else begin
         if (w_load_direct) begin
            r_sh_word <= word_in;
            r_sh_rem  <= w_nb_clamped;
            r_sh_last <= last_in;
         end else if (w_load_pref) begin
            r_sh_word  <= r_nxt_word;
            r_sh_rem   <= r_nxt_nb;
            r_sh_last  <= r_nxt_last;
            r_nxt_full <= 1'b0;
         end else if (w_byte_xfer) begin
            r_sh_word <= {8'h00, r_sh_word[8*WORD_BYTES-1:8]};
            r_sh_rem  <= r_sh_rem - c_ONE;
         end
         if (w_to_prefetch) begin
            r_nxt_word <= word_in;
            r_nxt_nb   <= w_nb_clamped;
            r_nxt_last <= last_in;
            r_nxt_full <= 1'b1;
         end
         if (w_byte_xfer && end_out) r_pkt_count <= r_pkt_count + 16'd1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_avst_word_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_avst_word_tx
//  Purpose  : Scoreboard bench for avst_word_tx: accepted words expand into
//             expected bytes, a monitor pops them as the DUT transfers bytes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_avst_word_tx;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] word_in;
   logic [3:0]  nbytes_in;
   logic        last_in;
   logic        word_valid;
   logic        word_ready;
   logic [7:0]  data_out;
   logic        valid_out;
   logic        end_out;
   logic        ready_out;
   logic        busy;
   logic [15:0] pkt_count;

   int          n_total = 0;
   int          n_bad   = 0;
   int          cyc     = 0;
   int          xfer_cnt = 0;
   int          last_xfer_cyc = 0;
   logic [8:0]  q[$];          // {end, data} expected in order
   logic [15:0] exp_pkt = 16'h0000;
   logic        pkt_chk = 1'b0;
   logic        hold_v  = 1'b0;
   logic [8:0]  hold_d;
   logic        rnd_done;

   avst_word_tx #(.WORD_BYTES(4), .NB_W(4)) dut (
      .clk(clk), .reset(reset), .word_in(word_in), .nbytes_in(nbytes_in),
      .last_in(last_in), .word_valid(word_valid), .word_ready(word_ready),
      .data_out(data_out), .valid_out(valid_out), .end_out(end_out),
      .ready_out(ready_out), .busy(busy), .pkt_count(pkt_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
      end
   endtask

   // Reference: a word contributes its clamped byte count, end flag only on
   // the final byte of a last word.
   task automatic model_push(input logic [31:0] w, input logic [3:0] nb_raw, input logic lst);
      int nb;
      nb = int'(nb_raw);
      if (nb == 0 || nb > 4) nb = 4;
      for (int i = 0; i < nb; i++)
         q.push_back({(lst && (i == nb - 1)), w[8*i +: 8]});
   endtask

   // Monitor / scoreboard, sampled mid-cycle.
   always @(negedge clk) begin
      if (reset) begin
         q.delete();
         exp_pkt = 16'h0000;
         pkt_chk = 1'b0;
         hold_v  = 1'b0;
      end else begin
         if (pkt_chk) begin
            chk("pkt_count", {16'h0, pkt_count}, {16'h0, exp_pkt});
            pkt_chk = 1'b0;
         end
         if (hold_v) begin
            chk("hold_valid", {31'h0, valid_out}, 32'h1);
            chk("hold_byte", {23'h0, end_out, data_out}, {23'h0, hold_d});
         end
         hold_v = 1'b0;
         if (valid_out) begin
            if (ready_out) begin
               if (q.size() == 0) begin
                  n_total++;
                  n_bad++;
                  $display("FAIL spurious_byte: got=%0h want=none", {end_out, data_out});
               end else begin
                  logic [8:0] e;
                  e = q.pop_front();
                  chk("byte", {23'h0, end_out, data_out}, {23'h0, e});
                  if (e[8]) begin
                     exp_pkt = exp_pkt + 16'd1;
                     pkt_chk = 1'b1;
                  end
               end
               xfer_cnt++;
               last_xfer_cyc = cyc;
            end else begin
               hold_v = 1'b1;
               hold_d = {end_out, data_out};
            end
         end
         if (word_valid && word_ready) model_push(word_in, nbytes_in, last_in);
      end
   end

   // Present one word and hold it until accepted; returns #1 after the edge.
   task automatic send_word(input logic [31:0] w, input logic [3:0] nb, input logic lst);
      bit acc;
      acc        = 1'b0;
      word_in    = w;
      nbytes_in  = nb;
      last_in    = lst;
      word_valid = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (word_ready) begin
            acc = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      word_valid = 1'b0;
      if (!acc) begin
         n_total++;
         n_bad++;
         $display("FAIL word_accept_timeout: got=0 want=1");
      end
   endtask

   task automatic wait_xfers(input int target);
      for (int k = 0; k < 100 && xfer_cnt < target; k++) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int k = 0; k < 2000; k++) begin
         @(posedge clk);
         #2;
         if (q.size() == 0 && !busy) break;
      end
      chk("drain_queue", q.size(), 32'h0);
      chk("drain_busy", {31'h0, busy}, 32'h0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int c0;
      int ca;
      logic [6:0] pat;
      int n;

      reset = 1'b1; word_in = '0; nbytes_in = '0; last_in = 1'b0;
      word_valid = 1'b0; ready_out = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {31'h0, valid_out}, 32'h0);
      chk("rst_end", {31'h0, end_out}, 32'h0);
      chk("rst_data", {24'h0, data_out}, 32'h0);
      chk("rst_pkt", {16'h0, pkt_count}, 32'h0);
      chk("rst_wready", {31'h0, word_ready}, 32'h0);
      reset = 1'b0;
      #1;
      chk("rel_wready", {31'h0, word_ready}, 32'h1);
      @(posedge clk);
      #1;

      // Single packet: four bytes on consecutive clocks starting right after accept.
      c0 = xfer_cnt;
      send_word(32'h44332211, 4'd4, 1'b1);
      ca = cyc;
      wait_xfers(c0 + 4);
      chk("sp_count", xfer_cnt - c0, 32'd4);
      chk("sp_last_cyc", last_xfer_cyc - ca, 32'd3);
      drain();
      chk("sp_pkt", {16'h0, pkt_count}, 32'd1);

      // Back-to-back words: five bytes without a gap.
      c0 = xfer_cnt;
      send_word(32'hDDCCBBAA, 4'd4, 1'b0);
      ca = cyc;
      send_word(32'h000000EE, 4'd1, 1'b1);
      wait_xfers(c0 + 5);
      chk("b2b_count", xfer_cnt - c0, 32'd5);
      chk("b2b_last_cyc", last_xfer_cyc - ca, 32'd4);
      drain();
      chk("b2b_pkt", {16'h0, pkt_count}, 32'd2);

      // Backpressure with a word parked in prefetch.
      pat = 7'b1101001;   // applied LSB first: 1,0,0,1,0,1,1
      send_word(32'h88776655, 4'd4, 1'b1);
      fork
         send_word(32'hCAFEBABE, 4'd4, 1'b1);
         begin
            for (int i = 0; i < 7; i++) begin
               ready_out = pat[i];
               if (i == 1) begin
                  chk("bp_wready", {31'h0, word_ready}, 32'h0);
                  chk("bp_busy", {31'h0, busy}, 32'h1);
               end
               @(posedge clk);
               #1;
            end
            ready_out = 1'b1;
         end
      join
      drain();
      chk("bp_pkt", {16'h0, pkt_count}, 32'd4);

      // nbytes clamp: 0 and 7 both mean four bytes.
      c0 = xfer_cnt;
      send_word(32'h0D0C0B0A, 4'd0, 1'b0);
      send_word(32'h1D1C1B1A, 4'd7, 1'b1);
      drain();
      chk("clamp_count", xfer_cnt - c0, 32'd8);

      // Randomized words against random backpressure.
      rnd_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               repeat ($urandom_range(0, 2)) @(posedge clk);
               #1;
               send_word($urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               ready_out = ($urandom_range(0, 2) != 0);
               @(posedge clk);
               #1;
            end
            ready_out = 1'b1;
         end
      join
      drain();

      // Reset after two bytes of a four-byte last packet.
      c0 = xfer_cnt;
      send_word(32'h5A5B5C5D, 4'd4, 1'b1);
      wait_xfers(c0 + 2);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_valid", {31'h0, valid_out}, 32'h0);
      chk("mid_rst_end", {31'h0, end_out}, 32'h0);
      chk("mid_rst_data", {24'h0, data_out}, 32'h0);
      chk("mid_rst_pkt", {16'h0, pkt_count}, 32'h0);
      chk("mid_rst_wready", {31'h0, word_ready}, 32'h0);
      chk("mid_rst_busy", {31'h0, busy}, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("mid_rel_wready", {31'h0, word_ready}, 32'h1);
      @(posedge clk);
      #1;
      chk("mid_pkt_zero", {16'h0, pkt_count}, 32'h0);
      send_word(32'h67666564, 4'd4, 1'b1);
      drain();
      chk("mid_next_pkt", {16'h0, pkt_count}, 32'd1);

      // Counter wrap with one-byte packets.
      n = 65535 - int'(exp_pkt);
      for (int i = 0; i < n; i++) send_word({24'h0, 8'(i)}, 4'd1, 1'b1);
      drain();
      chk("wrap_ffff", {16'h0, pkt_count}, 32'h0000FFFF);
      send_word(32'h000000F0, 4'd1, 1'b1);
      drain();
      chk("wrap_zero", {16'h0, pkt_count}, 32'h0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
